rocket_game_controller: RTL and testbench
=========================================

# rocket_game_controller

Top-level game sequencer for the lander. It owns the game state machine (idle, play, crash, level-up, game over) and tracks lives and level. It gates the player's up/down keys into the rocket position block, and holds that block in its start position whenever play is not live. It consumes the collision flag from the collision detector and the `cleared` flag from the rocket position block.

## Interface
- `LIVES`, default 3 — lives loaded at game start; range 1..3.
- `MAX_LEVEL`, default 9 — level saturation value; range 1..15.
- `HOLD_CYCLES`, default 50000000 — dwell in CRASH and LEVEL_UP, in Clock cycles (1 s at 50 MHz); range 1..2^28-1.

- `Clock` in 1 — system clock; all state changes on its rising edge.
- `Reset` in 1 — synchronous, active-low.
- `start` in 1 — start key, level-sensitive; the block edge-detects it internally.
- `upKey` in 1 — raw up key.
- `downKey` in 1 — raw down key.
- `collisionDetected` in 1 — level from the collision detector.
- `cleared` in 1 — level from the rocket position block; 1 means the rocket reached the top.
- `up` out 1 — gated up command to the rocket position block.
- `down` out 1 — gated down command to the rocket position block.
- `rocketRestart` out 1 — drives the rocket position block's collision/restart input; holds the rocket at its start position.
- `lives` out 2 — remaining lives.
- `level` out 4 — current level; 1-based during a game.
- `state` out 3 — encoding: IDLE=0, PLAY=1, CRASH=2, LEVEL_UP=3, GAME_OVER=4.
- `gameOver` out 1 — high exactly while in GAME_OVER.

## Operation
- Start edge detection:
  - `startPulse = start & ~start_d`.
  - `start_d` is registered every cycle and resets to 0, so a `start` held high through reset yields one pulse on the first cycle after reset.
- IDLE:
  - On `startPulse`: go to PLAY, load `lives` = LIVES, `level` = 1.
- PLAY:
  - If `collisionDetected`: go to CRASH, `lives` decrements by 1 (never below 0).
  - Else if `cleared`: go to LEVEL_UP, `level` increments, saturating at MAX_LEVEL.
  - Collision has priority when both are high in the same cycle.
  - `startPulse` is ignored.
- CRASH: dwell HOLD_CYCLES cycles, then go to GAME_OVER if `lives` == 0, else PLAY.
- LEVEL_UP: dwell HOLD_CYCLES cycles, then go to PLAY.
- GAME_OVER:
  - On `startPulse`: go to IDLE.
  - `lives` and `level` hold their final values until the next IDLE→PLAY load.
- Output decodes:
  - `up` = PLAY & `upKey`.
  - `down` = PLAY & `downKey` & ~`upKey` (up wins).
  - `rocketRestart` = ~PLAY, so it is high in IDLE, CRASH, LEVEL_UP and GAME_OVER. This forces the rocket position block to its start position and clears its `cleared` flag, so a stale `cleared` is never seen on re-entering PLAY.
- Dwell timer:
  - 28-bit down-counter, loaded with HOLD_CYCLES-1 on the transition into CRASH or LEVEL_UP.
  - Decrements every cycle while in those states.
  - The state exits on the cycle the counter reads 0.

## Timing
- Reset values (next rising edge with `Reset`=0): `state` IDLE, `lives` 0, `level` 0, timer 0, `start_d` 0.
  - Resulting outputs: `up`=0, `down`=0, `rocketRestart`=1, `gameOver`=0.
- Reset mid-game (any state) behaves identically; the timer is abandoned.
- `state`, `lives`, `level` and the timer are registers; they update 1 cycle after the qualifying input is sampled.
- `up`, `down`, `rocketRestart` and `gameOver` are combinational decodes of the `state` register, plus the key inputs for `up`/`down`.
  - A key change reaches `up`/`down` in the same cycle while in PLAY.
  - A state change reaches all four outputs in the cycle after the triggering input is sampled.
- CRASH and LEVEL_UP each occupy exactly HOLD_CYCLES cycles.
- `collisionDetected` and `cleared` are ignored outside PLAY.
- A collision sampled in PLAY on the last life goes PLAY → CRASH (`lives`=0) → GAME_OVER after HOLD_CYCLES.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, LIVES=3, MAX_LEVEL=9.
- Reset then `start` pulse → next cycle: `state`=1, `lives`=3, `level`=1, `rocketRestart`=0; holding `start` high produces no second transition.
- PLAY with `upKey`=1 and `downKey`=1 → `up`=1, `down`=0; in IDLE, any key combination → `up`=`down`=0.
- PLAY, `cleared`=1 for one cycle → `state`=3 for exactly 4 cycles, `level`=2, `rocketRestart`=1 throughout, then `state`=1.
  - Repeating this 9 times leaves `level` saturated at 9.
- Three collisions, each followed by the 4-cycle dwell → `lives` goes 2, 1, 0.
  - After the third dwell: `state`=4, `gameOver`=1.
  - Then a `start` pulse → `state`=0; a second pulse → `lives`=3, `level`=1.
- `collisionDetected`=1 and `cleared`=1 in the same PLAY cycle → `state`=2, `lives` decremented, `level` unchanged.
- `Reset`=0 asserted on the 2nd cycle of a CRASH dwell → next cycle: `state`=0, `lives`=0, `level`=0, `rocketRestart`=1; no late exit to PLAY occurs.

Source files
------------

// File: rtl/rocket_game_controller.sv
// rocket_game_controller
//   Game sequencer for the lander: IDLE -> PLAY -> (CRASH | LEVEL_UP) -> ...
//   -> GAME_OVER. Tracks lives and level. Gates the player's keys into the
//   rocket position block and holds that block at its start position whenever
//   play is not live.
//
// Ports
//   Clock             in   system clock, rising edge
//   Reset             in   synchronous, active-low
//   start             in   start key (level); edge-detected internally
//   upKey, downKey    in   raw player keys
//   collisionDetected in   collision level from the collision detector
//   cleared           in   rocket reached the top (from rocket position block)
//   up, down          out  gated key commands (up wins over down)
//   rocketRestart     out  high whenever not in PLAY; parks the rocket
//   lives      [1:0]  out  remaining lives
//   level      [3:0]  out  current level (1-based during a game)
//   state      [2:0]  out  IDLE=0 PLAY=1 CRASH=2 LEVEL_UP=3 GAME_OVER=4
//   gameOver          out  high exactly while in GAME_OVER
module rocket_game_controller #(
  parameter int LIVES       = 3,
  parameter int MAX_LEVEL   = 9,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       upKey,
  input  logic       downKey,
  input  logic       collisionDetected,
  input  logic       cleared,
  output logic       up,
  output logic       down,
  output logic       rocketRestart,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [2:0] state,
  output logic       gameOver
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_CRASH     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  localparam logic [27:0] HOLD_LOAD = 28'(HOLD_CYCLES - 1);
  localparam logic [1:0]  LIVES_LD  = 2'(LIVES);
  localparam logic [3:0]  MAX_LVL   = 4'(MAX_LEVEL);

  state_e      state_q, state_n;
  logic [1:0]  lives_q, lives_n;
  logic [3:0]  level_q, level_n;
  logic [27:0] timer_q, timer_n;
  logic        start_d;
  logic        start_pulse;

  // start_d resets to 0, so a start held through reset gives one pulse
  // on the first cycle out of reset.
  assign start_pulse = start & ~start_d;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      lives_q <= '0;
      level_q <= '0;
      timer_q <= '0;
      start_d <= 1'b0;
    end else begin
      state_q <= state_n;
      lives_q <= lives_n;
      level_q <= level_n;
      timer_q <= timer_n;
      start_d <= start;
    end
  end

  always_comb begin
    state_n = state_q;
    lives_n = lives_q;
    level_n = level_q;
    timer_n = timer_q;
    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          state_n = S_PLAY;
          lives_n = LIVES_LD;
          level_n = 4'd1;
        end
      end
      S_PLAY: begin
        // Collision wins over cleared when both arrive together.
        if (collisionDetected) begin
          state_n = S_CRASH;
          lives_n = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          timer_n = HOLD_LOAD;
        end else if (cleared) begin
          state_n = S_LEVEL_UP;
          level_n = (level_q >= MAX_LVL) ? MAX_LVL : level_q + 4'd1;
          timer_n = HOLD_LOAD;
        end
      end
      S_CRASH: begin
        // Exit on the cycle the timer reads 0: dwell is exactly HOLD_CYCLES.
        if (timer_q == 28'd0) state_n = (lives_q == 2'd0) ? S_GAME_OVER : S_PLAY;
        else                  timer_n = timer_q - 28'd1;
      end
      S_LEVEL_UP: begin
        if (timer_q == 28'd0) state_n = S_PLAY;
        else                  timer_n = timer_q - 28'd1;
      end
      S_GAME_OVER: begin
        if (start_pulse) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign up            = (state_q == S_PLAY) & upKey;
  assign down          = (state_q == S_PLAY) & downKey & ~upKey;
  assign rocketRestart = (state_q != S_PLAY);
  assign gameOver      = (state_q == S_GAME_OVER);
  assign lives         = lives_q;
  assign level         = level_q;
  assign state         = state_q;

endmodule

// File: tb/tb_rocket_game_controller.sv
// Bench for rocket_game_controller: directed scenarios with literal
// expectations, then randomized stimulus; a behavioural model tracks the
// game and a compare process checks every output on every falling edge.
module tb_rocket_game_controller;

  localparam int LIVES = 3;
  localparam int MAX_LEVEL = 9;
  localparam int HOLD = 4;

  logic       Clock, Reset, start, upKey, downKey, collisionDetected, cleared;
  logic       up, down, rocketRestart, gameOver;
  logic [1:0] lives;
  logic [3:0] level;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  rocket_game_controller #(.LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL), .HOLD_CYCLES(HOLD)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .upKey(upKey), .downKey(downKey),
    .collisionDetected(collisionDetected), .cleared(cleared), .up(up), .down(down),
    .rocketRestart(rocketRestart), .lives(lives), .level(level), .state(state),
    .gameOver(gameOver)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Behavioural model: game phase as a number, cycles spent in a dwell.
  int m_state = 0, m_lives = 0, m_level = 0, m_spent = 0;
  bit m_prev = 0, m_valid = 0;

  always @(posedge Clock) begin
    bit pulse;
    if (!Reset) begin
      m_state = 0; m_lives = 0; m_level = 0; m_spent = 0; m_prev = 0; m_valid = 1;
    end else begin
      pulse  = start && !m_prev;
      m_prev = start;
      if (m_state == 0) begin
        if (pulse) begin m_state = 1; m_lives = LIVES; m_level = 1; end
      end else if (m_state == 1) begin
        if (collisionDetected) begin
          m_state = 2; m_spent = 0;
          if (m_lives > 0) m_lives = m_lives - 1;
        end else if (cleared) begin
          m_state = 3; m_spent = 0;
          m_level = (m_level + 1 > MAX_LEVEL) ? MAX_LEVEL : m_level + 1;
        end
      end else if (m_state == 2 || m_state == 3) begin
        m_spent = m_spent + 1;
        if (m_spent == HOLD) m_state = (m_state == 2 && m_lives == 0) ? 4 : 1;
      end else if (m_state == 4) begin
        if (pulse) m_state = 0;
      end
    end
  end

  always @(negedge Clock) begin
    logic [12:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {3'(m_state), 2'(m_lives), 4'(m_level),
               (m_state == 1) && upKey, (m_state == 1) && downKey && !upKey,
               m_state != 1, m_state == 4};
      act_v = {state, lives, level, up, down, rocketRestart, gameOver};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got st/lv/lvl/up/dn/rr/go=%b want %b", $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  initial begin
    Reset = 0; start = 0; upKey = 0; downKey = 0; collisionDetected = 0; cleared = 0;
    tick(2);
    chk("rst_state", state, 0); chk("rst_lives", lives, 0); chk("rst_level", level, 0);
    chk("rst_rr", rocketRestart, 1); chk("rst_go", gameOver, 0);
    Reset = 1;
    upKey = 1; downKey = 1; #1;
    chk("idle_up", up, 0); chk("idle_down", down, 0);
    upKey = 0; downKey = 0;
    tick(1);
    start = 1; tick(1);
    chk("start_state", state, 1); chk("start_lives", lives, 3);
    chk("start_level", level, 1); chk("start_rr", rocketRestart, 0);
    tick(3);
    chk("start_held", state, 1);
    start = 0;
    upKey = 1; downKey = 1; #1;
    chk("play_up", up, 1); chk("play_down", down, 0);
    upKey = 0; #1;
    chk("play_down_only", down, 1);
    downKey = 0;
    cleared = 1; tick(1); cleared = 0;
    chk("lvlup_state", state, 3); chk("lvlup_level", level, 2); chk("lvlup_rr", rocketRestart, 1);
    for (int i = 0; i < HOLD - 1; i++) begin tick(1); chk("lvlup_dwell", state, 3); end
    tick(1); chk("lvlup_exit", state, 1);
    for (int i = 0; i < 8; i++) begin
      cleared = 1; tick(1); cleared = 0; tick(HOLD);
    end
    chk("level_sat", level, 9);
    collisionDetected = 1; cleared = 1; tick(1); collisionDetected = 0; cleared = 0;
    chk("both_state", state, 2); chk("both_lives", lives, 2); chk("both_level", level, 9);
    tick(HOLD); chk("crash1_exit", state, 1);
    collisionDetected = 1; tick(1); collisionDetected = 0;
    chk("crash2_lives", lives, 1);
    tick(HOLD);
    collisionDetected = 1; tick(1); collisionDetected = 0;
    chk("crash3_lives", lives, 0);
    tick(HOLD);
    chk("go_state", state, 4); chk("go_flag", gameOver, 1);
    start = 1; tick(1); start = 0;
    chk("go_to_idle", state, 0); chk("go_keep_level", level, 9);
    tick(1); start = 1; tick(1); start = 0;
    chk("restart_lives", lives, 3); chk("restart_level", level, 1);
    collisionDetected = 1; tick(1); collisionDetected = 0;
    tick(1);
    chk("mid_crash", state, 2);
    Reset = 0; tick(1); Reset = 1;
    chk("midrst_state", state, 0); chk("midrst_lives", lives, 0);
    chk("midrst_level", level, 0); chk("midrst_rr", rocketRestart, 1);
    tick(HOLD + 2);
    chk("no_late_exit", state, 0);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      Reset             = ($urandom_range(0, 299) != 0);
      start             = ($urandom_range(0, 5) == 0);
      collisionDetected = ($urandom_range(0, 9) == 0);
      cleared           = ($urandom_range(0, 5) == 0);
      upKey             = $urandom_range(0, 1);
      downKey           = $urandom_range(0, 1);
      tick(1);
    end
    Reset = 1; start = 0; collisionDetected = 0; cleared = 0;
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
